// File: rtl/cam_pkg.sv
// Shared CAM definitions: clog2 helper, encoded-address width derivation and
// the match-scanner FSM state type. Also used by the CAM array and write decoder.
package cam_pkg;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Encoded row-address width, never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } scan_state_t;

endpackage

// File: rtl/cam_priority_encoder.sv
// Lowest-index-first priority encoder over a CAM row-match vector.
// index   : lowest set bit position (0 when the vector is empty)
// nonzero : at least one bit set
// single  : at most one bit set
module cam_priority_encoder #(
  parameter int unsigned CAM_DEPTH  = 4,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic [CAM_DEPTH-1:0]  vec,
  output logic [ADDR_WIDTH-1:0] index,
  output logic                  nonzero,
  output logic                  single
);

  // Scan upward and keep the first hit so the lowest row wins.
  always_comb begin
    logic hit;
    hit   = 1'b0;
    index = '0;
    for (int unsigned i = 0; i < CAM_DEPTH; i++) begin
      if (vec[i] && !hit) begin
        index = ADDR_WIDTH'(i);
        hit   = 1'b1;
      end
    end
    nonzero = |vec;
    single  = $onehot0(vec);
  end

endmodule

// File: rtl/cam_match_scanner.sv
// CAM match scanner: captures a multi-hot row-match vector and emits encoded
// row addresses over a valid/ready handshake, lowest row first.
// Build option: define CAM_MULTI_MATCH_SCAN_EN to emit every matching row;
// otherwise only the lowest matching row is emitted per frame.
module cam_match_scanner
  import cam_pkg::*;
#(
  parameter int unsigned CAM_DEPTH  = 4,
  parameter int unsigned ADDR_WIDTH = addr_width(CAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CAM_DEPTH-1:0]  decoded_match_address,
  input  logic                  match_valid,
  output logic                  match_ready,
  output logic                  addr_valid,
  input  logic                  addr_ready,
  output logic [ADDR_WIDTH-1:0] match_addr,
  output logic                  match_found,
  output logic                  multi_match,
  output logic                  last
);

  scan_state_t state, state_next;
  logic [CAM_DEPTH-1:0] pending, pending_next;
  logic multi_q, multi_next;

  logic [ADDR_WIDTH-1:0] pend_index;
  logic pend_nonzero;
  logic pend_single;

  logic [ADDR_WIDTH-1:0] cap_index;
  logic cap_nonzero;
  logic cap_single;
  logic cap_multi;

  logic last_int;

  cam_priority_encoder #(
    .CAM_DEPTH  (CAM_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_pending_enc (
    .vec     (pending),
    .index   (pend_index),
    .nonzero (pend_nonzero),
    .single  (pend_single)
  );

  // Second encoder only supplies the popcount>1 test for the incoming vector.
  cam_priority_encoder #(
    .CAM_DEPTH  (CAM_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_capture_enc (
    .vec     (decoded_match_address),
    .index   (cap_index),
    .nonzero (cap_nonzero),
    .single  (cap_single)
  );

  assign cap_multi = cap_nonzero && !cap_single;

`ifdef CAM_MULTI_MATCH_SCAN_EN
  assign last_int = pend_single;
`else
  assign last_int = 1'b1;
`endif

  // State, pending vector and multi-match flag; reset wins over capture/transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      multi_q <= 1'b0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      multi_q <= multi_next;
    end
  end

  // Next-state: capture in IDLE, retire one result per transfer in EMIT.
  always_comb begin
    state_next   = state;
    pending_next = pending;
    multi_next   = multi_q;
    unique case (state)
      IDLE: begin
        if (match_valid) begin
          pending_next = decoded_match_address;
          multi_next   = cap_multi;
          state_next   = EMIT;
        end
      end
      EMIT: begin
        if (addr_ready) begin
          if (last_int) begin
            pending_next = '0;
            multi_next   = 1'b0;
            state_next   = IDLE;
          end else begin
            pending_next[pend_index] = 1'b0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Result outputs are driven only while a result is being offered.
  always_comb begin
    match_ready = (state == IDLE);
    addr_valid  = (state == EMIT);
    match_addr  = '0;
    match_found = 1'b0;
    multi_match = 1'b0;
    last        = 1'b0;
    if (state == EMIT) begin
      match_addr  = pend_index;
      match_found = pend_nonzero;
      multi_match = multi_q;
      last        = last_int;
    end
  end

endmodule

// File: tb/tb_cam_match_scanner.sv
// Self-checking bench for cam_match_scanner (CAM_DEPTH=4): directed frames
// with literal expectations, then random frames against a queue-based model.
module tb_cam_match_scanner;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DEPTH-1:0] decoded;
  logic          match_valid;
  logic          match_ready;
  logic          addr_valid;
  logic          addr_ready;
  logic [AW-1:0] match_addr;
  logic          match_found;
  logic          multi_match;
  logic          last;

  int unsigned total = 0;
  int unsigned bad   = 0;

  cam_match_scanner #(.CAM_DEPTH(DEPTH)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .decoded_match_address (decoded),
    .match_valid           (match_valid),
    .match_ready           (match_ready),
    .addr_valid            (addr_valid),
    .addr_ready            (addr_ready),
    .match_addr            (match_addr),
    .match_found           (match_found),
    .multi_match           (multi_match),
    .last                  (last)
  );

  always #5 clk = ~clk;

`ifdef CAM_MULTI_MATCH_SCAN_EN
  localparam bit SCAN = 1'b1;
`else
  localparam bit SCAN = 1'b0;
`endif

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    int unsigned addr;
    bit found;
    bit multi;
    bit lst;
  } result_t;

  result_t q[$];
  bit model_on   = 1'b0;
  bit just_reset = 1'b0;

  // Expand a captured vector into the list of results the frame must produce.
  function automatic void build_frame(input logic [DEPTH-1:0] v);
    int unsigned n;
    int unsigned hi;
    result_t r;
    n  = 0;
    hi = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (v[i]) begin
        n++;
        hi = i;
      end
    end
    if (n == 0) begin
      r.addr = 0; r.found = 0; r.multi = 0; r.lst = 1;
      q.push_back(r);
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (v[i]) begin
          r.addr  = i;
          r.found = 1;
          r.multi = (n > 1);
          r.lst   = SCAN ? (i == int'(hi)) : 1'b1;
          q.push_back(r);
          if (!SCAN) break;
        end
      end
    end
  endfunction

  // Model advance at every active edge from the inputs presented for it.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      model_on   = 1'b1;
      just_reset = 1'b1;
    end else begin
      just_reset = 1'b0;
      if (q.size() == 0) begin
        if (match_valid) build_frame(decoded);
      end else if (addr_ready) begin
        void'(q.pop_front());
      end
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (model_on) begin
      if (q.size() == 0) begin
        check("idle_match_ready", 32'(match_ready), 32'd1);
        check("idle_addr_valid", 32'(addr_valid), 32'd0);
        if (just_reset) begin
          check("rst_found", 32'(match_found), 32'd0);
          check("rst_multi", 32'(multi_match), 32'd0);
          check("rst_last", 32'(last), 32'd0);
          check("rst_addr", 32'(match_addr), 32'd0);
        end
      end else begin
        check("emit_match_ready", 32'(match_ready), 32'd0);
        check("emit_addr_valid", 32'(addr_valid), 32'd1);
        check("emit_addr", 32'(match_addr), 32'(q[0].addr));
        check("emit_found", 32'(match_found), 32'(q[0].found));
        check("emit_multi", 32'(multi_match), 32'(q[0].multi));
        check("emit_last", 32'(last), 32'(q[0].lst));
      end
    end
  end

  // ---------------- directed helpers ----------------
  // Present a vector at a falling edge and hold it until it is captured.
  task automatic send(input logic [DEPTH-1:0] v);
    int unsigned n;
    n = 0;
    @(negedge clk);
    match_valid = 1'b1;
    decoded     = v;
    while (!match_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!match_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    match_valid = 1'b0;
  endtask

  task automatic expect_res(input string name, input int unsigned a, input bit f,
                            input bit m, input bit l);
    check({name, "_valid"}, 32'(addr_valid), 32'd1);
    check({name, "_addr"}, 32'(match_addr), 32'(a));
    check({name, "_found"}, 32'(match_found), 32'(f));
    check({name, "_multi"}, 32'(multi_match), 32'(m));
    check({name, "_last"}, 32'(last), 32'(l));
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    addr_ready = 1'b1;
    @(negedge clk);
    while (!match_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(match_ready), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int unsigned frames;
    int unsigned cycles;
    bit cap_pending;

    rst         = 1'b1;
    decoded     = '0;
    match_valid = 1'b0;
    addr_ready  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_valid", 32'(addr_valid), 32'd0);
    check("reset_ready", 32'(match_ready), 32'd1);

    // Single match, latency 1, ready again two cycles after capture.
    addr_ready = 1'b1;
    send(4'b0100);
    @(negedge clk);
    expect_res("one", 2, 1, 0, 1);
    @(negedge clk);
    check("one_ready_back", 32'(match_ready), 32'd1);
    check("one_valid_low", 32'(addr_valid), 32'd0);

    // Multi match.
    send(4'b1011);
    @(negedge clk);
    if (SCAN) begin
      expect_res("multi0", 0, 1, 1, 0);
      @(negedge clk);
      expect_res("multi1", 1, 1, 1, 0);
      @(negedge clk);
      expect_res("multi3", 3, 1, 1, 1);
    end else begin
      expect_res("multi0", 0, 1, 1, 1);
    end
    @(negedge clk);
    check("multi_ready_back", 32'(match_ready), 32'd1);

    // Empty capture.
    send(4'b0000);
    @(negedge clk);
    expect_res("zero", 0, 0, 0, 1);
    @(negedge clk);
    check("zero_ready_back", 32'(match_ready), 32'd1);

    // Stall with a competing match_valid that must not be accepted.
    addr_ready = 1'b0;
    send(4'b0110);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      expect_res("stall", 1, 1, 1, !SCAN);
      check("stall_ready", 32'(match_ready), 32'd0);
      match_valid = 1'b1;
      decoded     = 4'b0001;
    end
    match_valid = 1'b0;
    drain();

    // Reset mid-frame, coincident with a transfer.
    addr_ready = 1'b1;
    send(4'b1111);
    @(negedge clk);
    expect_res("full0", 0, 1, 1, !SCAN);
    if (SCAN) begin
      @(negedge clk);
      expect_res("full1", 1, 1, 1, 0);
      @(negedge clk);
      expect_res("full2", 2, 1, 1, 0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", 32'(addr_valid), 32'd0);
    check("midrst_ready", 32'(match_ready), 32'd1);
    check("midrst_found", 32'(match_found), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("midrst_quiet", 32'(addr_valid), 32'd0);
    end

    // Reset coincident with a capture.
    rst         = 1'b1;
    match_valid = 1'b1;
    decoded     = 4'b0010;
    @(negedge clk);
    rst         = 1'b0;
    match_valid = 1'b0;
    check("rstcap_valid", 32'(addr_valid), 32'd0);
    check("rstcap_ready", 32'(match_ready), 32'd1);

    // Random frames with random backpressure.
    frames      = 0;
    cycles      = 0;
    cap_pending = 1'b0;
    while (frames < 10000 && cycles < 90000) begin
      @(negedge clk);
      cycles++;
      if (cap_pending) begin
        frames++;
        match_valid = 1'b0;
      end
      addr_ready = ($urandom_range(0, 3) != 0);
      if (!match_valid && $urandom_range(0, 1) == 1) begin
        match_valid = 1'b1;
        decoded     = 4'($urandom);
      end
      cap_pending = match_valid && match_ready;
    end
    check("random_frames", 32'(frames >= 10000), 32'd1);
    @(posedge clk);
    #1;
    match_valid = 1'b0;
    drain();

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cam_match_scanner.md
CAM_MATCH_SCANNER -- requirements
Module: cam_match_scanner

Interface
REQ-001 Parameter CAM_DEPTH, default 4, SHALL set the number of CAM rows and the width of the match vector.
REQ-002 Parameter ADDR_WIDTH, default clog2(CAM_DEPTH) with a minimum of 1, SHALL set the width of the encoded address.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 Port decoded_match_address  input  CAM_DEPTH  SHALL be the multi-hot row-match vector from the CAM array.
REQ-006 Port match_valid  input  1  SHALL qualify decoded_match_address.
REQ-007 Port match_ready  output  1  SHALL indicate that the block accepts a new match vector.
REQ-008 Port addr_valid  output  1  SHALL qualify the result outputs.
REQ-009 Port addr_ready  input  1  SHALL be the downstream acceptance of the current result.
REQ-010 Port match_addr  output  ADDR_WIDTH  SHALL carry the binary row index of the current match.
REQ-011 Port match_found  output  1  SHALL be high when the captured vector was non-zero.
REQ-012 Port multi_match  output  1  SHALL be high when the captured vector had more than one bit set.
REQ-013 Port last  output  1  SHALL mark the final result of the current frame.

Function
REQ-014 The FSM SHALL have two states: IDLE and EMIT.
REQ-015 In IDLE, match_ready SHALL be 1 and addr_valid SHALL be 0.
REQ-016 In EMIT, match_ready SHALL be 0 and addr_valid SHALL be 1.
REQ-017 A match_valid && match_ready cycle SHALL register the vector into pending, latch multi_match (popcount > 1), and move to EMIT, so the first result appears the next cycle (latency 1).
REQ-018 In EMIT, match_addr SHALL be the lowest set index of pending, where lowest index means highest priority.
REQ-019 In EMIT, last SHALL be 1 when pending has at most one bit set.
REQ-020 match_found SHALL be 1 when pending is non-zero.
REQ-021 An all-zero capture SHALL emit exactly one result with match_found=0, match_addr=0, last=1 and multi_match=0.
REQ-022 All result outputs SHALL stay stable while addr_valid && !addr_ready.
REQ-023 A transfer (addr_valid && addr_ready) on last=1 SHALL clear pending and return the FSM to IDLE.
REQ-024 A transfer on last=0 SHALL clear the emitted bit and remain in EMIT.
REQ-025 match_valid in EMIT SHALL be ignored and not queued; the upstream holds it until match_ready.
REQ-026 When CAM_DEPTH is not a power of two, match_addr SHALL never exceed CAM_DEPTH-1.
REQ-027 Back-to-back frames SHALL have exactly one IDLE cycle between a final transfer and the next capture.

Reset
REQ-028 rst SHALL force IDLE and pending=0, with outputs addr_valid=0, match_found=0, multi_match=0, last=0, match_addr=0, match_ready=1 in the cycle after rst.
REQ-029 rst asserted mid-frame SHALL discard all remaining matches; no result is emitted after the reset.
REQ-030 rst SHALL take priority over a simultaneous capture or transfer.

Configuration
REQ-031 With macro CAM_MULTI_MATCH_SCAN_EN defined, every set bit SHALL be emitted in ascending index order, one per transfer.
REQ-032 With macro CAM_MULTI_MATCH_SCAN_EN undefined, only the lowest set index SHALL be emitted with last=1; multi_match still reports extra matches, and every frame is one transfer.

Structure
REQ-033 Shared package cam_pkg SHALL hold the clog2 function, the FSM state typedef (IDLE, EMIT), and the ADDR_WIDTH derivation, shared with the CAM array and write decoder.
REQ-034 A combinational sub-module cam_priority_encoder SHALL compute the lowest set index, a non-zero flag, and a single-bit flag from a CAM_DEPTH vector.

Verification (CAM_DEPTH=4)
REQ-035 Vector 4'b0100, addr_ready=1 -> one result: addr=2, found=1, multi=0, last=1; match_ready high two cycles after the capture.
REQ-036 Vector 4'b1011, addr_ready=1, macro defined -> addr 0, 1, 3 on consecutive cycles with last only on 3 and multi=1 throughout; macro undefined -> single result addr=0, last=1, multi=1.
REQ-037 Vector 4'b0000 -> one result: found=0, addr=0, last=1.
REQ-038 Vector 4'b0110, addr_ready low for 3 cycles -> addr=1 held stable with valid high; a new match_valid during the stall is not accepted.
REQ-039 Vector 4'b1111, rst pulsed after the second transfer -> IDLE next cycle, addr_valid=0, no further results, match_ready=1.
REQ-040 Random vectors and random addr_ready over 10k frames -> the emitted address set equals the set bits of each vector, in ascending order.
